// File: rtl/mmc1_pkg.sv
// mmc1_pkg: shared encodings and constants for the synchronous MMC1 mapper
package mmc1_pkg;
  typedef enum logic [1:0] {SEL_CTRL, SEL_CHR0, SEL_CHR1, SEL_PRG} reg_sel_e;
  typedef enum logic [1:0] {MIR_ONE_LO, MIR_ONE_HI, MIR_VERT, MIR_HORZ} mirror_e;
  typedef enum logic [1:0] {PRG_32K_A, PRG_32K_B, PRG_FIX_FIRST, PRG_FIX_LAST} prg_mode_e;
  localparam logic [4:0] CTRL_RESET = 5'h0C;
  localparam int SHIFT_LEN = 5;
  localparam logic [2:0] LAST_BIT = 3'(SHIFT_LEN - 1);
endpackage

// File: rtl/mmc1_serial_loader.sv
// mmc1_serial_loader: consecutive-write filter, 5-bit serial shift and commit pulse
module mmc1_serial_loader
  import mmc1_pkg::*;
(
  input  logic       ck,
  input  logic       res,
  input  logic       cyc_ce,
  input  logic       wr_stb,
  input  logic [1:0] wr_sel,
  input  logic       wr_d7,
  input  logic       wr_d0,
  output logic       commit,
  output reg_sel_e   commit_sel,
  output logic [4:0] commit_val,
  output logic       d7_reset
);
  logic       last_wr_q, last_wr_d, acc;
  logic [3:0] sr_q, sr_d;
  logic [2:0] cnt_q, cnt_d;
  always_comb begin
    acc        = cyc_ce & wr_stb & !last_wr_q;
    last_wr_d  = cyc_ce ? wr_stb : last_wr_q;
    d7_reset   = acc & wr_d7;
    commit     = acc & !wr_d7 & (cnt_q == LAST_BIT);
    commit_sel = reg_sel_e'(wr_sel);
    commit_val = {wr_d0, sr_q};
    sr_d       = (d7_reset | commit) ? 4'd0 : acc ? {wr_d0, sr_q[3:1]} : sr_q;
    cnt_d      = (d7_reset | commit) ? 3'd0 : acc ? cnt_q + 3'd1 : cnt_q;
  end
  always_ff @(posedge ck) begin
    if (res) begin
      last_wr_q <= 1'b0;
      sr_q      <= 4'd0;
      cnt_q     <= 3'd0;
    end else begin
      last_wr_q <= last_wr_d;
      sr_q      <= sr_d;
      cnt_q     <= cnt_d;
    end
  end
endmodule

// File: rtl/mmc1_mapper_sync.sv
// mmc1_mapper_sync: MMC1-style register file and combinational PRG/CHR/CIRAM bank decode
module mmc1_mapper_sync
  import mmc1_pkg::*;
#(
  parameter int PRG_BANK_W = 4,
  parameter int CHR_BANK_W = 5
) (
  input  logic                  ck,
  input  logic                  res,
  input  logic                  cyc_ce,
  input  logic                  wr_stb,
  input  logic [1:0]            wr_sel,
  input  logic [7:0]            wr_d,
  input  logic                  cpu_a14,
  input  logic [2:0]            ppu_a,
  output logic [PRG_BANK_W-1:0] prg_bank,
  output logic [CHR_BANK_W-1:0] chr_bank,
  output logic                  ciram_a10,
  output logic                  prg_ram_en
);
  logic       commit, d7_reset;
  reg_sel_e   commit_sel;
  logic [4:0] commit_val;
  logic [4:0] ctrl_q, ctrl_d, chr0_q, chr0_d, chr1_q, chr1_d, prg_q, prg_d, chr_full;
  logic [3:0] p, prg_lo;
  mirror_e    mir;
  prg_mode_e  pm;
  mmc1_serial_loader u_loader (
    .ck(ck), .res(res), .cyc_ce(cyc_ce), .wr_stb(wr_stb), .wr_sel(wr_sel),
    .wr_d7(wr_d[7]), .wr_d0(wr_d[0]), .commit(commit), .commit_sel(commit_sel),
    .commit_val(commit_val), .d7_reset(d7_reset)
  );
  always_comb begin
    ctrl_d = d7_reset ? (ctrl_q | 5'h0C) : (commit && commit_sel == SEL_CTRL) ? commit_val : ctrl_q;
    chr0_d = (commit && commit_sel == SEL_CHR0) ? commit_val : chr0_q;
    chr1_d = (commit && commit_sel == SEL_CHR1) ? commit_val : chr1_q;
    prg_d  = (commit && commit_sel == SEL_PRG) ? commit_val : prg_q;
    mir    = mirror_e'(ctrl_q[1:0]);
    pm     = prg_mode_e'(ctrl_q[3:2]);
    p      = prg_q[3:0];
    ciram_a10 = mir == MIR_VERT ? ppu_a[0] : mir == MIR_HORZ ? ppu_a[1] : ctrl_q[0];
    prg_lo = pm == PRG_FIX_FIRST ? (cpu_a14 ? p : 4'h0) :
             pm == PRG_FIX_LAST  ? (cpu_a14 ? 4'hF : p) : {p[3:1], cpu_a14};
    chr_full = ctrl_q[4] ? (ppu_a[2] ? chr1_q : chr0_q) : {chr0_q[4:1], ppu_a[2]};
    chr_bank   = chr_full[CHR_BANK_W-1:0];
    prg_ram_en = !prg_q[4];
  end
  // The outer 256 KiB select rides on chr0[4] only in the 5-bit PRG build
  if (PRG_BANK_W == 5) begin : g_outer
    assign prg_bank = {chr0_q[4], prg_lo};
  end else begin : g_plain
    assign prg_bank = prg_lo;
  end
  always_ff @(posedge ck) begin
    if (res) begin
      ctrl_q <= CTRL_RESET;
      chr0_q <= 5'd0;
      chr1_q <= 5'd0;
      prg_q  <= 5'd0;
    end else begin
      ctrl_q <= ctrl_d;
      chr0_q <= chr0_d;
      chr1_q <= chr1_d;
      prg_q  <= prg_d;
    end
  end
endmodule

// File: tb/tb_mmc1_mapper_sync.sv
// tb_mmc1_mapper_sync: directed checks of serial loading, filtering, resets and bank decode
module tb_mmc1_mapper_sync;
  logic       ck = 0, res = 1, cyc_ce = 0, wr_stb = 0, cpu_a14 = 0;
  logic [1:0] wr_sel = 0;
  logic [7:0] wr_d = 0;
  logic [2:0] ppu_a = 0;
  logic [3:0] prg_bank;
  logic [4:0] chr_bank, chr_bank_5, prg_bank_5;
  logic [2:0] chr_bank_3;
  logic [3:0] prg_bank_a;
  logic       ciram_a10, prg_ram_en, ciram_a, ram_a, ciram_b, ram_b;
  int checks = 0, errors = 0;
  always #5 ck = ~ck;
  mmc1_mapper_sync u_dut (
    .ck(ck), .res(res), .cyc_ce(cyc_ce), .wr_stb(wr_stb), .wr_sel(wr_sel), .wr_d(wr_d),
    .cpu_a14(cpu_a14), .ppu_a(ppu_a), .prg_bank(prg_bank), .chr_bank(chr_bank),
    .ciram_a10(ciram_a10), .prg_ram_en(prg_ram_en)
  );
  mmc1_mapper_sync #(.CHR_BANK_W(3)) u_chr3 (
    .ck(ck), .res(res), .cyc_ce(cyc_ce), .wr_stb(wr_stb), .wr_sel(wr_sel), .wr_d(wr_d),
    .cpu_a14(cpu_a14), .ppu_a(ppu_a), .prg_bank(prg_bank_a), .chr_bank(chr_bank_3),
    .ciram_a10(ciram_a), .prg_ram_en(ram_a)
  );
  mmc1_mapper_sync #(.PRG_BANK_W(5)) u_prg5 (
    .ck(ck), .res(res), .cyc_ce(cyc_ce), .wr_stb(wr_stb), .wr_sel(wr_sel), .wr_d(wr_d),
    .cpu_a14(cpu_a14), .ppu_a(ppu_a), .prg_bank(prg_bank_5), .chr_bank(chr_bank_5),
    .ciram_a10(ciram_b), .prg_ram_en(ram_b)
  );
  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic idle();
    cyc_ce = 1; wr_stb = 0; @(posedge ck); #1; cyc_ce = 0;
  endtask
  task automatic wr(input logic [1:0] s, input logic [7:0] d);
    cyc_ce = 1; wr_stb = 1; wr_sel = s; wr_d = d; @(posedge ck); #1;
    wr_stb = 0; idle();
  endtask
  task automatic stray();
    cyc_ce = 0; wr_stb = 1; wr_d = 8'h01; @(posedge ck); #1; wr_stb = 0;
  endtask
  task automatic load(input logic [1:0] s, input logic [4:0] v);
    for (int i = 0; i < 5; i++) wr(s, {7'd0, v[i]});
  endtask
  task automatic probe(input logic a14, input logic [2:0] pa);
    cpu_a14 = a14; ppu_a = pa; #1;
  endtask
  initial begin
    repeat (2) @(posedge ck);
    #1 res = 0;
    probe(1, 3'b000);
    chk("rst_prg_a14_1", 8'(prg_bank), 8'h0F);
    chk("rst_prg5_a14_1", 8'(prg_bank_5), 8'h0F);
    probe(0, 3'b000);
    chk("rst_prg_a14_0", 8'(prg_bank), 8'h00);
    chk("rst_ram_en", 8'(prg_ram_en), 8'h01);
    chk("rst_ciram", 8'(ciram_a10), 8'h00);
    wr(2'd3, 8'h01); wr(2'd3, 8'h00); wr(2'd3, 8'h01); wr(2'd3, 8'h01); wr(2'd3, 8'h00);
    probe(0, 3'b000);
    chk("prg_d_a14_0", 8'(prg_bank), 8'h0D);
    probe(1, 3'b000);
    chk("prg_d_a14_1", 8'(prg_bank), 8'h0F);
    chk("ram_en_on", 8'(prg_ram_en), 8'h01);
    load(2'd3, 5'h1D);
    chk("ram_en_off", 8'(prg_ram_en), 8'h00);
    probe(0, 3'b000);
    chk("prg_1d_a14_0", 8'(prg_bank), 8'h0D);
    // Back-to-back writes: only the first shifts in
    cyc_ce = 1; wr_stb = 1; wr_sel = 2'd1; wr_d = 8'h01; @(posedge ck); #1;
    @(posedge ck); #1; wr_stb = 0; idle();
    for (int i = 0; i < 4; i++) wr(2'd1, 8'h00);
    load(2'd0, 5'h10);
    probe(0, 3'b000);
    chk("filter_chr0", 8'(chr_bank), 8'h01);
    chk("mode32k_a14_0", 8'(prg_bank), 8'h0C);
    probe(1, 3'b000);
    chk("mode32k_a14_1", 8'(prg_bank), 8'h0D);
    wr(2'd2, 8'h01); wr(2'd2, 8'h01); wr(2'd2, 8'h01); wr(2'd2, 8'h80);
    probe(1, 3'b000);
    chk("d7_prg_a14_1", 8'(prg_bank), 8'h0F);
    probe(0, 3'b000);
    chk("d7_prg_a14_0", 8'(prg_bank), 8'h0D);
    chk("d7_chr0", 8'(chr_bank), 8'h01);
    chk("d7_ciram", 8'(ciram_a10), 8'h00);
    load(2'd2, 5'h1A);
    probe(0, 3'b100);
    chk("d7_count_clr", 8'(chr_bank), 8'h1A);
    wr(2'd3, 8'h01); wr(2'd3, 8'h01);
    res = 1; @(posedge ck); #1 res = 0;
    probe(1, 3'b100);
    chk("res_prg_a14_1", 8'(prg_bank), 8'h0F);
    chk("res_chr_8k", 8'(chr_bank), 8'h01);
    chk("res_ram_en", 8'(prg_ram_en), 8'h01);
    probe(0, 3'b100);
    chk("res_prg_a14_0", 8'(prg_bank), 8'h00);
    load(2'd3, 5'h05);
    chk("res_count_clr", 8'(prg_bank), 8'h05);
    load(2'd0, 5'h12); load(2'd1, 5'h03); load(2'd2, 5'h1A);
    probe(0, 3'b001);
    chk("vert_ciram_1", 8'(ciram_a10), 8'h01);
    chk("chr4k_lo", 8'(chr_bank), 8'h03);
    chk("chr4k_lo_w3", 8'(chr_bank_3), 8'h03);
    probe(0, 3'b100);
    chk("chr4k_hi", 8'(chr_bank), 8'h1A);
    chk("chr4k_hi_w3", 8'(chr_bank_3), 8'h02);
    probe(0, 3'b010);
    chk("vert_ciram_0", 8'(ciram_a10), 8'h00);
    load(2'd0, 5'h03);
    chk("horz_ciram_1", 8'(ciram_a10), 8'h01);
    probe(0, 3'b001);
    chk("horz_ciram_0", 8'(ciram_a10), 8'h00);
    chk("chr8k_lo", 8'(chr_bank), 8'h02);
    probe(0, 3'b101);
    chk("chr8k_hi", 8'(chr_bank), 8'h03);
    load(2'd0, 5'h01);
    probe(0, 3'b010);
    chk("one_hi_ciram", 8'(ciram_a10), 8'h01);
    load(2'd0, 5'h0C);
    for (int i = 0; i < 5; i++) begin
      stray();
      wr(2'd1, {7'd0, i == 4});
    end
    probe(1, 3'b000);
    chk("outer_a14_1", 8'(prg_bank_5), 8'h1F);
    chk("outer_w4", 8'(prg_bank), 8'h0F);
    probe(0, 3'b000);
    chk("outer_a14_0", 8'(prg_bank_5), 8'h15);
    load(2'd1, 5'h00);
    probe(1, 3'b000);
    chk("outer_clr", 8'(prg_bank_5), 8'h0F);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
